// File: rtl/mips_pc_pkg.sv
// Shared definitions for the fetch unit: next-PC select encodings,
// default vectors, FSM state encoding and a small alignment helper.
package mips_pc_pkg;

    // One-hot PCsel encodings driven by the EX stage
    localparam logic [4:0] SELECT_PC_INC      = 5'b00001;
    localparam logic [4:0] SELECT_PC_ADD      = 5'b00010;
    localparam logic [4:0] SELECT_PC_JUMP     = 5'b00100;
    localparam logic [4:0] SELECT_PC_REGISTER = 5'b01000;
    localparam logic [4:0] SELECT_PC_VECTOR   = 5'b10000;

    // Default architectural vectors
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'hBFC0_0380;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // A word address is misaligned when either of its low two bits is set
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational redirect target selection with fixed priority
// vector > register > jump > add; a bad register target falls back
// to the exception vector and raises addr_err_raw.
module pc_next_mux
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [4:0]  sel_i,
    input  logic [31:0] pc_offset_i,
    input  logic [25:0] pc_jump_i,
    input  logic [31:0] ex_pc_plus4_i,
    input  logic [31:0] reg_target_i,
    output logic        redirect_o,
    output logic [31:0] target_o,
    output logic        addr_err_raw_o
);

    // Any non-inc select bit asks for a redirect
    assign redirect_o = ((sel_i & 5'b11110) != 5'b00000);

    // Priority select of the redirect target
    always_comb begin
        target_o       = ex_pc_plus4_i;
        addr_err_raw_o = 1'b0;
        if ((sel_i & SELECT_PC_VECTOR) != 5'b00000) begin
            target_o = EXC_VECTOR;
        end else if ((sel_i & SELECT_PC_REGISTER) != 5'b00000) begin
            if (is_misaligned(reg_target_i)) begin
                target_o       = EXC_VECTOR;
                addr_err_raw_o = 1'b1;
            end else begin
                target_o = reg_target_i;
            end
        end else if ((sel_i & SELECT_PC_JUMP) != 5'b00000) begin
            target_o = {ex_pc_plus4_i[31:28], pc_jump_i, 2'b00};
        end else if ((sel_i & SELECT_PC_ADD) != 5'b00000) begin
            target_o = ex_pc_plus4_i + pc_offset_i;
        end else if ((sel_i & SELECT_PC_INC) != 5'b00000) begin
            // Sequential flow: no redirect, target is not consumed
            target_o = ex_pc_plus4_i;
        end else begin
            // All-zero select behaves as inc
            target_o = ex_pc_plus4_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher.
// Issues requests from pc, presents responses to ID with a valid/stall
// handshake, and applies EX-stage redirects, dropping stale responses.
module pc_fetch_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [4:0]  PCsel,
    input  logic [31:0] PCoffset,
    input  logic [25:0] PCjump,
    input  logic [31:0] ex_pc_plus4,
    input  logic [31:0] reg_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        addr_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         drop_q, drop_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         addr_err_q, addr_err_d;

    logic         sel_redirect_s;
    logic         redirect_s;
    logic [31:0]  target_s;
    logic         addr_err_raw_s;

    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_mux (
        .sel_i          (PCsel),
        .pc_offset_i    (PCoffset),
        .pc_jump_i      (PCjump),
        .ex_pc_plus4_i  (ex_pc_plus4),
        .reg_target_i   (reg_target),
        .redirect_o     (sel_redirect_s),
        .target_o       (target_s),
        .addr_err_raw_o (addr_err_raw_s)
    );

    assign redirect_s = ex_valid & sel_redirect_s;

    // Next-state logic: fetch FSM, pc update, ID handshake and redirects
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        // ID consumes whenever valid and not stalled
        if_valid_d = if_valid_q & id_stall;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        addr_err_d = redirect_s & addr_err_raw_s;
        case (state_q)
            ST_FETCH: begin
                if (redirect_s) begin
                    pc_d       = target_s;
                    if_valid_d = 1'b0;
                    if (req_q && imem_gnt) begin
                        // Granted request now fetches a squashed address
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (req_q && imem_gnt) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (redirect_s) begin
                    pc_d       = target_s;
                    if_valid_d = 1'b0;
                    if (imem_rvalid) begin
                        // Stale response lands now: discard it directly
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q - 32'd4;
                        if_valid_d = 1'b1;
                        state_d    = id_stall ? ST_HOLD : ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    pc_d       = target_s;
                    if_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!id_stall) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        // Request is a registered copy of "next state is FETCH"
        req_d = (state_d == ST_FETCH);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_VECTOR;
            req_q      <= 1'b0;
            drop_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branch/jump/register
// redirects, priority, ID stall hold, redirect vs response, async reset.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  PCsel = 5'b00000;
    logic [31:0] PCoffset = 32'd0;
    logic [25:0] PCjump = 26'd0;
    logic [31:0] ex_pc_plus4 = 32'd0;
    logic [31:0] reg_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        addr_err;

    int checks = 0;
    int failures = 0;

    pc_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ex_valid    (ex_valid),
        .PCsel       (PCsel),
        .PCoffset    (PCoffset),
        .PCjump      (PCjump),
        .ex_pc_plus4 (ex_pc_plus4),
        .reg_target  (reg_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Grant the pending request, return data one cycle later, check ID side
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check1({tag, ".req"}, imem_req, 1'b1);
        check32({tag, ".addr"}, imem_addr, addr);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check1({tag, ".if_valid"}, if_valid, 1'b1);
        check32({tag, ".if_pc"}, if_pc, addr);
        check32({tag, ".if_instr"}, if_instr, data);
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0;
        PCsel    = 5'b00000;
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check1("rst.req", imem_req, 1'b0);
        check1("rst.if_valid", if_valid, 1'b0);
        check32("rst.if_instr", if_instr, 32'h0000_0000);
        check32("rst.if_pc", if_pc, 32'h0000_0000);
        check1("rst.addr_err", addr_err, 1'b0);
        check32("rst.addr", imem_addr, 32'hBFC0_0000);
        reset_n = 1'b1;
        @(negedge clk);
        check1("first.req", imem_req, 1'b1);

        // Sequential fetch
        fetch_one("seq0", 32'hBFC0_0000, 32'h1111_0000);
        fetch_one("seq1", 32'hBFC0_0004, 32'h1111_0004);
        fetch_one("seq2", 32'hBFC0_0008, 32'h1111_0008);
        check32("seq.next_addr", imem_addr, 32'hBFC0_000C);

        // Branch while a request is in flight: response must be dropped
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        ex_valid    = 1'b1;
        PCsel       = 5'b00010;
        ex_pc_plus4 = 32'h0040_0010;
        PCoffset    = 32'hFFFF_FFF0;
        @(negedge clk);
        clear_ex();
        check1("br.wait_req", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_DEAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check1("br.dropped_valid", if_valid, 1'b0);
        check32("br.if_pc_kept", if_pc, 32'hBFC0_0008);
        fetch_one("br.target", 32'h0040_0000, 32'h2222_0000);

        // Jump from FETCH without grant
        ex_valid    = 1'b1;
        PCsel       = 5'b00100;
        ex_pc_plus4 = 32'h9000_0004;
        PCjump      = 26'h3FF_FFFF;
        @(negedge clk);
        clear_ex();
        check1("jmp.squash", if_valid, 1'b0);
        fetch_one("jmp.target", 32'h9FFF_FFFC, 32'h3333_0000);

        // Misaligned register target coincident with a grant
        imem_gnt   = 1'b1;
        ex_valid   = 1'b1;
        PCsel      = 5'b01000;
        reg_target = 32'h0040_0002;
        @(negedge clk);
        clear_ex();
        imem_gnt = 1'b0;
        check1("reg.addr_err_hi", addr_err, 1'b1);
        check1("reg.wait_req", imem_req, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check1("reg.addr_err_lo", addr_err, 1'b0);
        check1("reg.dropped_valid", if_valid, 1'b0);
        fetch_one("reg.vector", 32'hBFC0_0380, 32'h4444_0000);

        // Priority: vector beats an aligned register target
        ex_valid   = 1'b1;
        PCsel      = 5'b11000;
        reg_target = 32'h0040_0000;
        @(negedge clk);
        check32("prio.addr", imem_addr, 32'hBFC0_0380);
        check1("prio.addr_err", addr_err, 1'b0);
        // PCsel ignored without ex_valid
        ex_valid = 1'b0;
        PCsel    = 5'b00100;
        @(negedge clk);
        PCsel = 5'b00000;
        check32("novalid.addr", imem_addr, 32'hBFC0_0380);

        // ID stall over a response: hold outputs, no new request
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_0000;
        id_stall    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            check1("stall.valid", if_valid, 1'b1);
            check32("stall.instr", if_instr, 32'h5555_0000);
            check32("stall.pc", if_pc, 32'hBFC0_0380);
            check1("stall.no_req", imem_req, 1'b0);
        end
        id_stall = 1'b0;
        @(negedge clk);
        check1("unstall.valid", if_valid, 1'b0);
        check1("unstall.req", imem_req, 1'b1);
        check32("unstall.addr", imem_addr, 32'hBFC0_0384);

        // Redirect coincident with the response (carry discarded in add)
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBEEF_BEEF;
        ex_valid    = 1'b1;
        PCsel       = 5'b00010;
        ex_pc_plus4 = 32'hFFFF_FFF8;
        PCoffset    = 32'h0000_1028;
        @(negedge clk);
        clear_ex();
        imem_rvalid = 1'b0;
        check1("coin.valid", if_valid, 1'b0);
        check32("coin.instr_kept", if_instr, 32'h5555_0000);
        fetch_one("coin.target", 32'h0000_1020, 32'h6666_0000);

        // Asynchronous reset while waiting for a response
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check1("arst.req", imem_req, 1'b0);
        check1("arst.valid", if_valid, 1'b0);
        check32("arst.instr", if_instr, 32'h0000_0000);
        check32("arst.pc", if_pc, 32'h0000_0000);
        check32("arst.addr", imem_addr, 32'hBFC0_0000);
        @(negedge clk);
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_0000;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check1("stale.valid", if_valid, 1'b0);
        fetch_one("post_rst", 32'hBFC0_0000, 32'h8888_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
